// File: rtl/stream_downscaler.sv
// Nearest-neighbour stream downscaler: keeps the source pixels that fall on the
// output sampling grid and forwards them through a single output register.
`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 1920
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 1080
`endif

module stream_downscaler #(
    parameter int PIXEL_BITS = 32,
    parameter int IN_WIDTH   = `LAPTOP_WIDTH,
    parameter int IN_HEIGHT  = `LAPTOP_HEIGHT,
    parameter int FRAC_BITS  = 16,
    parameter int DIM_BITS   = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [DIM_BITS+FRAC_BITS-1:0] scale_step,
    input  logic [DIM_BITS-1:0]           out_width,
    input  logic [DIM_BITS-1:0]           out_height,
    input  logic                          in_valid,
    input  logic [PIXEL_BITS-1:0]         in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [PIXEL_BITS-1:0]         out_data,
    input  logic                          out_ready,
    output logic                          out_sof,
    output logic                          out_eol,
    output logic                          out_eof,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err
);
    localparam int STEP_BITS = DIM_BITS + FRAC_BITS;
    // One spare integer bit: an accumulator can run one step past the last coordinate.
    localparam int ACC_BITS  = STEP_BITS + 1;
    localparam logic [DIM_BITS-1:0] LAST_X = DIM_BITS'(IN_WIDTH - 1);
    localparam logic [DIM_BITS-1:0] LAST_Y = DIM_BITS'(IN_HEIGHT - 1);
    localparam logic [DIM_BITS-1:0] MAX_W  = DIM_BITS'(IN_WIDTH);
    localparam logic [DIM_BITS-1:0] MAX_H  = DIM_BITS'(IN_HEIGHT);
    localparam logic [DIM_BITS-1:0] ONE    = DIM_BITS'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH
    } state_t;

    state_t                 state_q, state_d;
    logic [STEP_BITS-1:0]   step_q, step_d;
    logic [DIM_BITS-1:0]    outW_q, outW_d;
    logic [DIM_BITS-1:0]    outH_q, outH_d;
    logic [DIM_BITS-1:0]    srcX_q, srcX_d;
    logic [DIM_BITS-1:0]    srcY_q, srcY_d;
    logic [DIM_BITS-1:0]    outJ_q, outJ_d;
    logic [DIM_BITS-1:0]    outI_q, outI_d;
    logic [ACC_BITS-1:0]    accX_q, accX_d;
    logic [ACC_BITS-1:0]    accY_q, accY_d;
    logic                   outValid_q, outValid_d;
    logic [PIXEL_BITS-1:0]  outData_q, outData_d;
    logic                   outSof_q, outSof_d;
    logic                   outEol_q, outEol_d;
    logic                   outEof_q, outEof_d;
    logic                   cfgErr_q, cfgErr_d;

    logic                   accept;
    logic                   rowHit;
    logic                   colHit;
    logic                   keep;
    logic                   cfgOk;
    logic                   lastCol;
    logic                   lastRow;
    logic [ACC_BITS-1:0]    stepExt;

    assign in_ready = (state_q == ACTIVE) && (!outValid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign stepExt  = {1'b0, step_q};
    assign rowHit   = ({1'b0, srcY_q} == accY_q[ACC_BITS-1:FRAC_BITS]) && (outI_q < outH_q);
    assign colHit   = ({1'b0, srcX_q} == accX_q[ACC_BITS-1:FRAC_BITS]) && (outJ_q < outW_q);
    assign keep     = accept && rowHit && colHit;
    assign lastCol  = (outJ_q == outW_q - ONE);
    assign lastRow  = (outI_q == outH_q - ONE);

    assign cfgOk = (scale_step[STEP_BITS-1:FRAC_BITS] != '0)
                && (out_width  != '0) && (out_width  <= MAX_W)
                && (out_height != '0) && (out_height <= MAX_H);

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        outW_d     = outW_q;
        outH_d     = outH_q;
        srcX_d     = srcX_q;
        srcY_d     = srcY_q;
        outJ_d     = outJ_q;
        outI_d     = outI_q;
        accX_d     = accX_q;
        accY_d     = accY_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outSof_d   = outSof_q;
        outEol_d   = outEol_q;
        outEof_d   = outEof_q;
        cfgErr_d   = cfgErr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cfgErr_d = !cfgOk;
                    if (cfgOk) begin
                        state_d = ACTIVE;
                        step_d  = scale_step;
                        outW_d  = out_width;
                        outH_d  = out_height;
                        srcX_d  = '0;
                        srcY_d  = '0;
                        outJ_d  = '0;
                        outI_d  = '0;
                        accX_d  = '0;
                        accY_d  = '0;
                    end
                end
            end
            ACTIVE: begin
                if (accept && (srcX_q == LAST_X) && (srcY_q == LAST_Y)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!outValid_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (keep) begin
            outValid_d = 1'b1;
            outData_d  = in_data;
            outSof_d   = (outI_q == '0) && (outJ_q == '0);
            outEol_d   = lastCol;
            outEof_d   = lastCol && lastRow;
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end

        // A row that matched always kept its column 0, so rowHit at the wrap means it produced output.
        if (accept) begin
            if (keep) begin
                accX_d = accX_q + stepExt;
                outJ_d = outJ_q + ONE;
            end
            if (srcX_q == LAST_X) begin
                srcX_d = '0;
                srcY_d = srcY_q + ONE;
                accX_d = '0;
                outJ_d = '0;
                if (rowHit) begin
                    accY_d = accY_q + stepExt;
                    outI_d = outI_q + ONE;
                end
            end else begin
                srcX_d = srcX_q + ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            step_q     <= '0;
            outW_q     <= '0;
            outH_q     <= '0;
            srcX_q     <= '0;
            srcY_q     <= '0;
            outJ_q     <= '0;
            outI_q     <= '0;
            accX_q     <= '0;
            accY_q     <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSof_q   <= 1'b0;
            outEol_q   <= 1'b0;
            outEof_q   <= 1'b0;
            cfgErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            outW_q     <= outW_d;
            outH_q     <= outH_d;
            srcX_q     <= srcX_d;
            srcY_q     <= srcY_d;
            outJ_q     <= outJ_d;
            outI_q     <= outI_d;
            accX_q     <= accX_d;
            accY_q     <= accY_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outSof_q   <= outSof_d;
            outEol_q   <= outEol_d;
            outEof_q   <= outEof_d;
            cfgErr_q   <= cfgErr_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_sof   = outSof_q;
    assign out_eol   = outEol_q;
    assign out_eof   = outEof_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FLUSH) && !outValid_q;
    assign cfg_err   = cfgErr_q;

endmodule

// File: tb/tb_stream_downscaler.sv
// Randomized bench for stream_downscaler on an 8x8 source frame, checked against
// a nearest-neighbour model computed directly from output coordinates.
module tb_stream_downscaler;
    localparam int PIXEL_BITS = 32;
    localparam int IN_W       = 8;
    localparam int IN_H       = 8;
    localparam int FRAC_BITS  = 16;
    localparam int DIM_BITS   = 16;
    localparam int NPIX       = IN_W * IN_H;

    logic                          clock = 1'b0;
    logic                          reset_n;
    logic                          start;
    logic [DIM_BITS+FRAC_BITS-1:0] scale_step;
    logic [DIM_BITS-1:0]           out_width;
    logic [DIM_BITS-1:0]           out_height;
    logic                          in_valid;
    logic [PIXEL_BITS-1:0]         in_data;
    logic                          in_ready;
    logic                          out_valid;
    logic [PIXEL_BITS-1:0]         out_data;
    logic                          out_ready;
    logic                          out_sof;
    logic                          out_eol;
    logic                          out_eof;
    logic                          busy;
    logic                          done;
    logic                          cfg_err;

    typedef struct {
        logic [PIXEL_BITS-1:0] data;
        logic                  sof;
        logic                  eol;
        logic                  eof;
    } pix_t;

    pix_t                  expQ[$];
    logic [PIXEL_BITS-1:0] srcMem[NPIX];
    int                    checks   = 0;
    int                    failures = 0;

    stream_downscaler #(
        .PIXEL_BITS(PIXEL_BITS),
        .IN_WIDTH  (IN_W),
        .IN_HEIGHT (IN_H),
        .FRAC_BITS (FRAC_BITS),
        .DIM_BITS  (DIM_BITS)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .scale_step(scale_step),
        .out_width (out_width),
        .out_height(out_height),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Output (i,j) samples source (floor(i*step), floor(j*step)); grid points off the frame never appear.
    task automatic buildModel(input logic [31:0] step, input int w, input int h);
        pix_t p;
        longint r;
        longint c;
        expQ.delete();
        for (int i = 0; i < h; i++) begin
            for (int j = 0; j < w; j++) begin
                r = (longint'(i) * longint'(step)) >> FRAC_BITS;
                c = (longint'(j) * longint'(step)) >> FRAC_BITS;
                if (r < IN_H && c < IN_W) begin
                    p.data = srcMem[int'(r) * IN_W + int'(c)];
                    p.sof  = (i == 0) && (j == 0);
                    p.eol  = (j == w - 1);
                    p.eof  = (j == w - 1) && (i == h - 1);
                    expQ.push_back(p);
                end
            end
        end
    endtask

    function automatic int maxOut(input logic [31:0] step);
        int n = 0;
        while (((longint'(n) * longint'(step)) >> FRAC_BITS) < IN_W) n++;
        return n;
    endfunction

    task automatic applyStimulus(input logic [31:0] step, input logic [15:0] w, input logic [15:0] h);
        @(posedge clock);
        #1;
        start      = 1'b1;
        scale_step = step;
        out_width  = w;
        out_height = h;
        @(posedge clock);
        #1;
        start      = 1'b0;
        scale_step = $urandom;
        out_width  = 16'($urandom);
        out_height = 16'($urandom);
    endtask

    // mode: 0 = out_ready held high, 1 = toggling 1-0, 2 = random
    task automatic runFrame(input logic [31:0] step, input int w, input int h, input int mode,
                            input int abortAt, input bit midStart, input bit checkLatency);
        int idx, cyc, got, expTotal, lastAcc, doneCyc, doneCnt;
        bit stallPrev;
        logic [PIXEL_BITS-1:0] prevData;
        logic [2:0] prevFlags;
        pix_t e;

        for (int k = 0; k < NPIX; k++) srcMem[k] = $urandom;
        buildModel(step, w, h);
        expTotal = expQ.size();

        in_valid = 1'b0;
        applyStimulus(step, 16'(w), 16'(h));
        checkOutput("busyAfterStart", busy, 1'b1);
        checkOutput("cfgErrAfterStart", cfg_err, 1'b0);

        idx = 0; cyc = 0; got = 0; lastAcc = -1; doneCyc = -1; doneCnt = 0;
        stallPrev = 1'b0; prevData = '0; prevFlags = '0;
        in_valid  = (checkLatency) ? 1'b1 : 1'($urandom_range(3, 0) != 0);
        in_data   = srcMem[idx % NPIX];
        out_ready = (mode == 2) ? 1'($urandom) : 1'b1;

        while (cyc < 3000) begin
            @(negedge clock);
            if (stallPrev) begin
                checkOutput("stallValid", out_valid, 1'b1);
                checkOutput("stallData", out_data, prevData);
                checkOutput("stallFlags", {out_sof, out_eol, out_eof}, prevFlags);
            end
            checkOutput("inReady", in_ready, (idx < NPIX) && (!out_valid || out_ready));
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("outputCount", got + 1, expTotal);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("outData", out_data, e.data);
                    checkOutput("outFlags", {out_sof, out_eol, out_eof}, {e.sof, e.eol, e.eof});
                end
                got++;
            end
            stallPrev = out_valid && !out_ready;
            prevData  = out_data;
            prevFlags = {out_sof, out_eol, out_eof};
            if (in_valid && in_ready) begin
                idx++;
                if (idx == NPIX) lastAcc = cyc;
            end
            if (done) begin
                doneCnt++;
                doneCyc = cyc;
            end
            if (abortAt > 0 && idx >= abortAt) break;
            if (doneCnt > 0 && cyc >= doneCyc + 2) break;

            @(posedge clock);
            cyc++;
            #1;
            in_valid  = (checkLatency) ? 1'b1 : 1'($urandom_range(3, 0) != 0);
            in_data   = srcMem[idx % NPIX];
            start     = midStart && (cyc == 10);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom);
            endcase
        end

        start = 1'b0;
        if (abortAt == 0) begin
            in_valid = 1'b0;
            checkOutput("outputCount", got, expTotal);
            checkOutput("doneCount", doneCnt, 1);
            if (checkLatency) checkOutput("doneLatency", doneCyc - lastAcc, 2);
            checkOutput("busyAfterDone", busy, 1'b0);
            checkOutput("cfgErrEnd", cfg_err, 1'b0);
        end
    endtask

    initial begin
        logic [31:0] step;
        int mw;

        reset_n    = 1'b0;
        start      = 1'b0;
        scale_step = '0;
        out_width  = '0;
        out_height = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("resetOutValid", out_valid, 1'b0);
        checkOutput("resetInReady", in_ready, 1'b0);
        checkOutput("resetBusy", busy, 1'b0);
        checkOutput("resetDone", done, 1'b0);
        checkOutput("resetCfgErr", cfg_err, 1'b0);
        checkOutput("resetOutData", out_data, '0);
        reset_n = 1'b1;

        $display("[TB] pass-through, step 1.0, 8x8");
        runFrame(32'h10000, 8, 8, 0, 0, 1'b0, 1'b1);
        $display("[TB] step 2.0, 4x4");
        runFrame(32'h20000, 4, 4, 0, 0, 1'b0, 1'b0);
        $display("[TB] step 1.5, 5x5");
        runFrame(32'h18000, 5, 5, 0, 0, 1'b0, 1'b0);
        $display("[TB] step 2.0, toggling out_ready");
        runFrame(32'h20000, 4, 4, 1, 0, 1'b0, 1'b0);

        $display("[TB] invalid configurations");
        applyStimulus(32'h0FFFF, 16'd4, 16'd4);
        checkOutput("cfgErrSmallStep", cfg_err, 1'b1);
        checkOutput("busySmallStep", busy, 1'b0);
        applyStimulus(32'h20000, 16'd0, 16'd4);
        checkOutput("cfgErrZeroWidth", cfg_err, 1'b1);
        checkOutput("busyZeroWidth", busy, 1'b0);
        applyStimulus(32'h10000, 16'd8, 16'd9);
        checkOutput("cfgErrTallOut", cfg_err, 1'b1);
        checkOutput("busyTallOut", busy, 1'b0);
        runFrame(32'h20000, 4, 4, 2, 0, 1'b0, 1'b0);

        $display("[TB] reset mid-frame");
        runFrame(32'h10000, 8, 8, 0, 20, 1'b0, 1'b0);
        #2;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("midRstOutValid", out_valid, 1'b0);
        checkOutput("midRstOutData", out_data, '0);
        checkOutput("midRstBusy", busy, 1'b0);
        checkOutput("midRstInReady", in_ready, 1'b0);
        checkOutput("midRstDone", done, 1'b0);
        @(posedge clock);
        #1;
        reset_n  = 1'b1;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            checkOutput("idleOutValid", out_valid, 1'b0);
            checkOutput("idleInReady", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        runFrame(32'h10000, 8, 8, 0, 0, 1'b0, 1'b1);

        $display("[TB] randomized frames");
        for (int t = 0; t < 6; t++) begin
            step = $urandom_range(32'h3FFFF, 32'h10000);
            mw   = maxOut(step);
            runFrame(step, int'($urandom_range(mw, 1)), int'($urandom_range(mw, 1)),
                     int'($urandom_range(2, 0)), 0, (t == 2), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
